// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with busy scoreboard and clear sweep.
// Optional same-cycle write-to-read bypass when RF_BYPASS_EN is defined.
module regfile_mp #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   parameter int NWR   = 1,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr_req,
   output logic                ready,
   input  logic [NWR-1:0]      we,
   input  logic [NWR*AW-1:0]   waddr,
   input  logic [NWR*XLEN-1:0] wdata,
   input  logic                alloc_valid,
   input  logic [AW-1:0]       alloc_addr,
   input  logic [NRD*AW-1:0]   raddr,
   output logic [NRD*XLEN-1:0] rdata,
   output logic [NRD-1:0]      rbusy
);

   localparam logic [0:0] S_CLEAR = 1'b0;
   localparam logic [0:0] S_IDLE  = 1'b1;

   logic [0:0]      state;
   logic [AW-1:0]   cnt;
   logic [NREGS-1:1] busy;
   logic [XLEN-1:0] regs [1:NREGS-1];

   assign ready = (state == S_IDLE);

   // Sweep control and busy scoreboard; later write ports override earlier ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_CLEAR;
         cnt   <= AW'(1);
         busy  <= '0;
      end else begin
         unique case (state)
            S_CLEAR: begin
               cnt <= cnt + AW'(1);
               if (cnt == AW'(NREGS - 1))
                  state <= S_IDLE;
            end
            default: begin
               if (clr_req) begin
                  state <= S_CLEAR;
                  cnt   <= AW'(1);
                  busy  <= '0;
               end else begin
                  for (int i = 0; i < NWR; i++) begin
                     if (we[i] && waddr[i*AW +: AW] != '0)
                        busy[waddr[i*AW +: AW]] <= 1'b0;
                  end
                  if (alloc_valid && alloc_addr != '0)
                     busy[alloc_addr] <= 1'b1;
               end
            end
         endcase
      end
   end

   // Storage: zeroed one entry per cycle while sweeping, else port writes.
   always_ff @(posedge clk) begin
      if (state == S_CLEAR) begin
         regs[cnt] <= '0;
      end else if (!clr_req) begin
         for (int i = 0; i < NWR; i++) begin
            if (we[i] && waddr[i*AW +: AW] != '0)
               regs[waddr[i*AW +: AW]] <= wdata[i*XLEN +: XLEN];
         end
      end
   end

   // Combinational read ports; operands look not-ready while sweeping.
   always_comb begin
      logic [AW-1:0] ra;
      ra    = '0;
      rdata = '0;
      rbusy = '1;
      if (state == S_IDLE) begin
         for (int p = 0; p < NRD; p++) begin
            ra       = raddr[p*AW +: AW];
            rbusy[p] = 1'b0;
            if (ra != '0) begin
               rdata[p*XLEN +: XLEN] = regs[ra];
               rbusy[p]              = busy[ra];
`ifdef RF_BYPASS_EN
               for (int w = 0; w < NWR; w++) begin
                  if (we[w] && !clr_req && waddr[w*AW +: AW] == ra) begin
                     rdata[p*XLEN +: XLEN] = wdata[w*XLEN +: XLEN];
                     rbusy[p]              = 1'b0;
                  end
               end
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vectors plus sweep/reset sequences for regfile_mp.
// Expected values depend on RF_BYPASS_EN where same-cycle reads are checked.
module tb_regfile_mp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int NWR   = 2;
   localparam int AW    = 5;

   logic                clk;
   logic                rst;
   logic                clr_req;
   logic                ready;
   logic [NWR-1:0]      we;
   logic [NWR*AW-1:0]   waddr;
   logic [NWR*XLEN-1:0] wdata;
   logic                alloc_valid;
   logic [AW-1:0]       alloc_addr;
   logic [NRD*AW-1:0]   raddr;
   logic [NRD*XLEN-1:0] rdata;
   logic [NRD-1:0]      rbusy;

   int checks;
   int failures;

   regfile_mp #(
      .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)
   ) dut (
      .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready),
      .we(we), .waddr(waddr), .wdata(wdata),
      .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
      .raddr(raddr), .rdata(rdata), .rbusy(rbusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wa0;
      logic [4:0]  wa1;
      logic [31:0] wd0;
      logic [31:0] wd1;
      logic        av;
      logic [4:0]  aa;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] ed0;
      logic        eb0;
      logic [31:0] ed1;
      logic        eb1;
   } vec_t;

   vec_t vec [12];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      we = '0; waddr = '0; wdata = '0;
      alloc_valid = 1'b0; alloc_addr = '0;
      clr_req = 1'b0;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!ready && n < 100) begin
         tick();
         n++;
      end
   endtask

   logic [31:0] byp_d;
   int n;

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      raddr = '0;
      idle_in();

      vec[0]  = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0,
                  5'd6, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0};
      vec[1]  = '{2'b01, 5'd0, 5'd0, 32'h1234, 32'h0, 1'b0, 5'd0,
                  5'd5, 5'd0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0};
      vec[2]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7,
                  5'd0, 5'd5, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0};
      vec[3]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0,
                  5'd7, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0};
      vec[4]  = '{2'b01, 5'd7, 5'd0, 32'hA5, 32'h0, 1'b0, 5'd0,
                  5'd5, 5'd0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0};
      vec[5]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0,
                  5'd7, 5'd5, 32'hA5, 1'b0, 32'hDEADBEEF, 1'b0};
      vec[6]  = '{2'b10, 5'd0, 5'd7, 32'h0, 32'hBB, 1'b1, 5'd7,
                  5'd5, 5'd6, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0};
      vec[7]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0,
                  5'd7, 5'd6, 32'hBB, 1'b1, 32'h0, 1'b0};
      vec[8]  = '{2'b11, 5'd3, 5'd3, 32'h11, 32'h22, 1'b0, 5'd0,
                  5'd7, 5'd8, 32'hBB, 1'b1, 32'h0, 1'b0};
      vec[9]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0,
                  5'd3, 5'd7, 32'h22, 1'b0, 32'hBB, 1'b1};
      vec[10] = '{2'b11, 5'd10, 5'd11, 32'h100, 32'h200, 1'b0, 5'd0,
                  5'd3, 5'd3, 32'h22, 1'b0, 32'h22, 1'b0};
      vec[11] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0,
                  5'd10, 5'd11, 32'h100, 1'b0, 32'h200, 1'b0};

      // reset state
      raddr = {5'd3, 5'd5};
      tick();
      tick();
      chk("rst_ready", ready, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_rbusy", rbusy, 2'b11);
      rst = 1'b0;
      wait_ready(n);
      chk("sweep_len", n, 31);

      // every register cleared and not busy
      for (int r = 1; r < NREGS; r++) begin
         raddr = {5'd0, 5'(r)};
         #1;
         chk($sformatf("clr_x%0d", r), {rbusy[0], rdata[31:0]}, 0);
      end

      // table-driven vectors: reads checked before the row's edge
      for (int i = 0; i < 12; i++) begin
         we = vec[i].we;
         waddr = {vec[i].wa1, vec[i].wa0};
         wdata = {vec[i].wd1, vec[i].wd0};
         alloc_valid = vec[i].av;
         alloc_addr = vec[i].aa;
         raddr = {vec[i].ra1, vec[i].ra0};
         #1;
         chk($sformatf("v%0d_d0", i), rdata[31:0], vec[i].ed0);
         chk($sformatf("v%0d_b0", i), rbusy[0], vec[i].eb0);
         chk($sformatf("v%0d_d1", i), rdata[63:32], vec[i].ed1);
         chk($sformatf("v%0d_b1", i), rbusy[1], vec[i].eb1);
         tick();
      end
      idle_in();

      // same-cycle write/read of x9
`ifdef RF_BYPASS_EN
      byp_d = 32'h55;
`else
      byp_d = 32'h0;
`endif
      we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h55};
      raddr = {5'd0, 5'd9};
      #1;
      chk("byp_same_d", rdata[31:0], byp_d);
      chk("byp_same_b", rbusy[0], 0);
      tick();
      idle_in();
      #1;
      chk("byp_next_d", rdata[31:0], 32'h55);

      // write plus alloc of x12 in one cycle
`ifdef RF_BYPASS_EN
      byp_d = 32'h66;
`else
      byp_d = 32'h0;
`endif
      we = 2'b10; waddr = {5'd12, 5'd0}; wdata = {32'h66, 32'h0};
      alloc_valid = 1'b1; alloc_addr = 5'd12;
      raddr = {5'd12, 5'd0};
      #1;
      chk("bya_same_d", rdata[63:32], byp_d);
      chk("bya_same_b", rbusy[1], 0);
      tick();
      idle_in();
      #1;
      chk("bya_next_d", rdata[63:32], 32'h66);
      chk("bya_next_b", rbusy[1], 1);

      // clear sweep with writes/allocs ignored throughout
      we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'h77};
      tick();
      idle_in();
      raddr = {5'd12, 5'd4};
      #1;
      chk("x4_pre", rdata[31:0], 32'h77);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      chk("clr_ready", ready, 0);
      chk("clr_rdata", rdata, 0);
      chk("clr_rbusy", rbusy, 2'b11);
      we = 2'b11; waddr = {5'd4, 5'd4}; wdata = {32'h99, 32'h99};
      alloc_valid = 1'b1; alloc_addr = 5'd4;
      clr_req = 1'b1;
      wait_ready(n);
      idle_in();
      #1;
      chk("clr_len", n, 31);
      chk("clr_x4_d", rdata[31:0], 0);
      chk("clr_x4_b", rbusy[0], 0);
      chk("clr_x12_b", rbusy[1], 0);

      // reset at sweep edge 10 restarts the sweep
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int e = 0; e < 10; e++) tick();
      chk("mid_ready", ready, 0);
      rst = 1'b1;
      #1;
      chk("mid_rst_b", rbusy, 2'b11);
      tick();
      rst = 1'b0;
      wait_ready(n);
      chk("mid_len", n, 31);
      raddr = {5'd31, 5'd1};
      #1;
      chk("mid_rd", {rbusy, rdata}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a per-register busy scoreboard, a sequential clear engine and optional write-to-read bypass. It is the next-generation register file for the core's decode/writeback stages. Issue allocates destination registers, writeback clears them, and decode reads operands together with their readiness. Register 0 is hardwired to zero and is never busy.

## Interface
Parameters:
- XLEN, 32: data width.
- NREGS, 32: register count; power of two, ≥ 2.
- NRD, 2: read port count, ≥ 1.
- NWR, 1: write port count, ≥ 1.
- AW, $clog2(NREGS): derived address width; not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- clr_req  in  1  start a full clear sweep; sampled in IDLE only.
- ready  out  1  high when state is IDLE; reset value 0.
- we  in  NWR  per-port write enable.
- waddr  in  NWR*AW  write addresses; port i occupies bits [i*AW +: AW].
- wdata  in  NWR*XLEN  write data, packed the same way.
- alloc_valid  in  1  mark alloc_addr busy.
- alloc_addr  in  AW  register to allocate.
- raddr  in  NRD*AW  read addresses.
- rdata  out  NRD*XLEN  read data; combinational.
- rbusy  out  NRD  per-port operand not ready; combinational.

## Operation
- State machine: CLEAR and IDLE. Reset forces CLEAR, sets the sweep counter to 1 and clears all busy bits.
- CLEAR:
  - Each edge writes 0 to regs[cnt] and increments cnt.
  - When cnt == NREGS-1 is cleared, the next state is IDLE.
  - In CLEAR, we, alloc_valid and clr_req are ignored.
  - rdata is forced to 0 and rbusy to all ones.
- IDLE, clr_req=1: next state is CLEAR with cnt=1 and all busy bits cleared. Pending writes and allocs in that same cycle are dropped.
- Writes (IDLE only):
  - Port i with we[i]=1 and waddr≠0 writes wdata to regs[waddr] and clears busy[waddr].
  - If several ports target the same address, the highest port index wins.
  - Writes to address 0 are discarded.
- Alloc (IDLE only): alloc_valid=1 and alloc_addr≠0 sets busy[alloc_addr]. If a write to the same address happens in the same cycle, the set wins and busy stays 1.
- Reads:
  - Address 0 returns rdata=0 and rbusy=0.
  - Otherwise rdata=regs[raddr] and rbusy=busy[raddr], subject to bypass (see Configuration).
- Register 0 has no storage.
- Reset mid-sweep restarts the sweep from cnt=1.

## Timing
- Writes and allocs take effect on the edge they are sampled. Without bypass, the new value is visible on the read outputs from the following cycle.
- Read path is zero-latency combinational from raddr, storage and busy, plus we, waddr and wdata when bypass is enabled.
- Sweep length:
  - After rst deasserts, ready rises after the (NREGS-1)th rising edge.
  - A clr_req sampled at edge k drops ready after edge k. Entries 1..NREGS-1 clear at edges k+1..k+NREGS-1, and ready is high after edge k+NREGS-1.
- ready is registered (state==IDLE); no combinational path from clr_req to ready.
- Outputs under rst: ready=0, rdata=0, rbusy all ones.

## Configuration
- RF_BYPASS_EN defined:
  - A read port whose raddr≠0 matches an active write in the same cycle returns that port's wdata (highest index wins) and rbusy=0.
  - This holds even if an alloc to the same address occurs that cycle.
  - Applies in IDLE only.
- RF_BYPASS_EN undefined: reads return stored values and the registered busy bit. Same-cycle writes become visible one cycle later.

## Test plan
- Reset sweep: assert rst, release. Check ready=0 for exactly 31 edges, then 1. All 31 registers read 0 with rbusy=0 (NREGS=32).
- Write/read: write 0xDEADBEEF to x5, read x5 next cycle and get 0xDEADBEEF. Write 0x1234 to x0, read x0 and get 0 with rbusy=0.
- Scoreboard: alloc x7 and check rbusy=1. Write x7=0xA5 and check rbusy=0, rdata=0xA5. Alloc and write x7 in the same cycle and check rbusy stays 1.
- Multi-write (NWR=2): both ports write x3, port0=0x11 and port1=0x22 → x3 reads 0x22.
- Bypass: with RF_BYPASS_EN, write x9=0x55 while reading x9 → rdata=0x55 and rbusy=0 in the same cycle. Without the macro, the same cycle shows the old value and the next cycle shows 0x55.
- Clear mid-operation:
  - Write x4=0x77, pulse clr_req: ignored writes during the sweep leave x4=0 afterward.
  - Assert rst at sweep edge 10: sweep restarts and ready rises 31 edges after release.
